// File: rtl/cache_controller_pkg.sv
// Shared definitions for the 2-way set-associative write-through data cache.
//   INDEX_W / TAG_W : address decode field widths (64 sets, 10-bit tags)
//   BASE            : data-memory base address removed before decode
//   state_t         : controller FSM encoding
//   cache_offset    : helper returning the base-relative address
package cache_controller_pkg;

    localparam int          INDEX_W = 6;
    localparam int          TAG_W   = 10;
    localparam int          SETS    = 1 << INDEX_W;
    localparam logic [31:0] BASE    = 32'd1024;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR      = 2'd2
    } state_t;

    // Addresses below BASE wrap around; such addresses are outside the
    // mapped range and their decode carries no meaning.
    function automatic logic [31:0] cache_offset(input logic [31:0] address);
        return address - BASE;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the cache controller and SRAM_controller.
//   Pipeline side : r_en, w_en, address, write_data -> cache; read_data, ready <- cache
//   SRAM side     : sram_r_en, sram_w_en, sram_address, sram_wdata -> SRAM;
//                   sram_rdata, sram_ready <- SRAM
// Modports:
//   slave  : the cache controller
//   master : the environment (MEM stage plus SRAM_controller)
//
// Handshake: the pipeline holds r_en/w_en, address and write_data stable
// while ready=0 (ready=0 is the freeze). A request completes in the cycle
// where ready=1. Towards SRAM the cache holds sram_r_en/sram_w_en high until
// the cycle in which sram_ready=1 is seen; the request drops one cycle later.
interface cache_controller_if;
    logic        r_en;
    logic        w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  r_en, w_en, address, write_data,
        output read_data, ready,
        output sram_r_en, sram_w_en, sram_address, sram_wdata,
        input  sram_rdata, sram_ready
    );

    modport master (
        output r_en, w_en, address, write_data,
        input  read_data, ready,
        input  sram_r_en, sram_w_en, sram_address, sram_wdata,
        output sram_rdata, sram_ready
    );
endinterface

// File: rtl/cache_controller_way.sv
// One way of the cache: valid bits, tag array and data array for all sets.
// Asynchronous read at index_i, synchronous write.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears valid bits)
//   index_i      : set index for both read and write
//   we_i         : write enable; marks the line valid and stores tag_i/data_i
//   tag_i/data_i : write values
//   valid_o/tag_o/data_o : contents of the addressed line
module cache_controller_way
    import cache_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic               we_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [31:0]        data_i,
    output logic               valid_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [31:0]        data_o
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[index_i]  <= tag_i;
            data_q[index_i] <= data_i;
        end
    end

    assign valid_o = valid_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign data_o  = data_q[index_i];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache sitting
// between the ARM MEM stage and SRAM_controller. One 32-bit word per block.
// Read hits complete in the same cycle; read misses and all writes go to SRAM
// and hold ready low (pipeline freeze) until SRAM reports sram_ready.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous, active-high
//   bus         : pipeline and SRAM signals (see cache_controller_if)
//   state_dbg_o : current FSM state, for observation only
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cache_controller_if.slave  bus,
    output state_t             state_dbg_o
);

    state_t           state_q;
    logic             sram_r_en_q;
    logic             sram_w_en_q;
    logic [SETS-1:0]  lru_q;        // per set: the way that is the next victim

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]        a_off;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_addr_bits;

    assign a_off = cache_offset(bus.address);
    assign index = a_off[INDEX_W+1:2];
    assign tag   = a_off[TAG_W+INDEX_W+1:INDEX_W+2];
    // Byte offset and bits above the tag do not take part in lookup.
    assign unused_addr_bits = ^{a_off[31:TAG_W+INDEX_W+2], a_off[1:0]};

    // ------------------------------------------------------------------
    // Ways
    // ------------------------------------------------------------------
    logic              valid0, valid1;
    logic [TAG_W-1:0]  tag0, tag1;
    logic [31:0]       data0, data1;
    logic              we0, we1;
    logic [31:0]       way_wdata;

    cache_controller_way u_way0 (
        .clk_i   (clk),
        .rst_i   (reset),
        .index_i (index),
        .we_i    (we0),
        .tag_i   (tag),
        .data_i  (way_wdata),
        .valid_o (valid0),
        .tag_o   (tag0),
        .data_o  (data0)
    );

    cache_controller_way u_way1 (
        .clk_i   (clk),
        .rst_i   (reset),
        .index_i (index),
        .we_i    (we1),
        .tag_i   (tag),
        .data_i  (way_wdata),
        .valid_o (valid1),
        .tag_o   (tag1),
        .data_o  (data1)
    );

    // ------------------------------------------------------------------
    // Hit / victim
    // ------------------------------------------------------------------
    logic        hit0, hit1, hit, hit_way, victim;
    logic [31:0] hit_data;
    logic        fill, wr_hit;

    assign hit0     = valid0 && (tag0 == tag);
    assign hit1     = valid1 && (tag1 == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;          // both ways never hold the same tag
    assign hit_data = hit1 ? data1 : data0;

    // Fill an empty way first (way0 before way1), otherwise the LRU way.
    assign victim = !valid0 ? 1'b0 :
                    !valid1 ? 1'b1 :
                    lru_q[index];

    assign fill   = (state_q == S_RD_MISS) && bus.sram_ready;
    assign wr_hit = (state_q == S_WR) && bus.sram_ready && hit;

    // A write hit rewrites the same tag into an already valid line, so the
    // fill port doubles as the data-update port.
    assign we0       = (fill && !victim) || (wr_hit && hit0);
    assign we1       = (fill &&  victim) || (wr_hit && hit1);
    assign way_wdata = fill ? bus.sram_rdata : bus.write_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sram_r_en_q <= 1'b0;
            sram_w_en_q <= 1'b0;
            lru_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // r_en has priority; a simultaneous w_en is ignored.
                    if (bus.r_en) begin
                        if (hit) begin
                            lru_q[index] <= ~hit_way;
                        end else begin
                            state_q     <= S_RD_MISS;
                            sram_r_en_q <= 1'b1;
                        end
                    end else if (bus.w_en) begin
                        state_q     <= S_WR;
                        sram_w_en_q <= 1'b1;
                    end
                end
                S_RD_MISS: begin
                    if (bus.sram_ready) begin
                        lru_q[index] <= ~victim;
                        state_q      <= S_IDLE;
                        sram_r_en_q  <= 1'b0;
                    end
                end
                S_WR: begin
                    if (bus.sram_ready) begin
                        if (hit) begin
                            lru_q[index] <= ~hit_way;
                        end
                        state_q     <= S_IDLE;
                        sram_w_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    sram_r_en_q <= 1'b0;
                    sram_w_en_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline-facing outputs (combinational so hits and SRAM completions
    // unfreeze the pipeline in the same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        bus.ready     = 1'b1;
        bus.read_data = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.r_en) begin
                    if (hit) begin
                        bus.read_data = hit_data;
                    end else begin
                        bus.ready = 1'b0;
                    end
                end else if (bus.w_en) begin
                    bus.ready = 1'b0;
                end
            end
            S_RD_MISS: begin
                bus.ready = bus.sram_ready;
                if (bus.sram_ready) begin
                    bus.read_data = bus.sram_rdata;
                end
            end
            S_WR: begin
                bus.ready = bus.sram_ready;
            end
            default: begin
                bus.ready = 1'b1;
            end
        endcase
    end

    assign bus.sram_r_en    = sram_r_en_q;
    assign bus.sram_w_en    = sram_w_en_q;
    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.write_data;
    assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
    import cache_controller_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_controller_if bus ();
    state_t state_dbg;

    cache_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .state_dbg_o (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every completed load is compared against the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.r_en === 1'b1 && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got 0x%08h, expected no load completion", bus.read_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", bus.read_data, mon_exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input bit miss, input int lat, input bit with_w);
        @(posedge clk); #1;
        bus.r_en       = 1'b1;
        bus.w_en       = with_w;
        bus.address    = a;
        bus.write_data = 32'h0BAD0BAD;
        exp_q.push_back(d);
        @(negedge clk);
        if (!miss) begin
            check("hit_ready", 32'(bus.ready), 32'd1);
            check("hit_no_sram_r_en", 32'(bus.sram_r_en), 32'd0);
            @(posedge clk); #1;
            bus.r_en = 1'b0;
            bus.w_en = 1'b0;
            @(negedge clk);
            check("hit_after_sram_r_en", 32'(bus.sram_r_en), 32'd0);
            check("hit_after_sram_w_en", 32'(bus.sram_w_en), 32'd0);
        end else begin
            check("miss_ready_low", 32'(bus.ready), 32'd0);
            repeat (lat) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("miss_sram_r_en", 32'(bus.sram_r_en), 32'd1);
                check("miss_wait_ready", 32'(bus.ready), 32'd0);
            end
            check("miss_sram_address", bus.sram_address, a);
            @(posedge clk); #1;
            bus.sram_ready = 1'b1;
            bus.sram_rdata = d;
            @(negedge clk);
            check("miss_done_ready", 32'(bus.ready), 32'd1);
            @(posedge clk); #1;
            bus.r_en       = 1'b0;
            bus.w_en       = 1'b0;
            bus.sram_ready = 1'b0;
            bus.sram_rdata = 32'd0;
            @(negedge clk);
            check("miss_req_drop", 32'(bus.sram_r_en), 32'd0);
            check("miss_back_idle", 32'(state_dbg), 32'(S_IDLE));
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
        @(posedge clk); #1;
        bus.w_en       = 1'b1;
        bus.address    = a;
        bus.write_data = d;
        @(negedge clk);
        check("wr_ready_low", 32'(bus.ready), 32'd0);
        repeat (lat) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("wr_sram_w_en", 32'(bus.sram_w_en), 32'd1);
            check("wr_no_sram_r_en", 32'(bus.sram_r_en), 32'd0);
            check("wr_wait_ready", 32'(bus.ready), 32'd0);
        end
        check("wr_sram_address", bus.sram_address, a);
        check("wr_sram_wdata", bus.sram_wdata, d);
        @(posedge clk); #1;
        bus.sram_ready = 1'b1;
        @(negedge clk);
        check("wr_done_ready", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        bus.w_en       = 1'b0;
        bus.sram_ready = 1'b0;
        @(negedge clk);
        check("wr_req_drop", 32'(bus.sram_w_en), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset          = 1'b1;
        bus.r_en       = 1'b0;
        bus.w_en       = 1'b0;
        bus.address    = 32'h400;
        bus.write_data = 32'd0;
        bus.sram_rdata = 32'd0;
        bus.sram_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_sram_r_en", 32'(bus.sram_r_en), 32'd0);
        check("rst_sram_w_en", 32'(bus.sram_w_en), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;

        // 1. cold miss, SRAM answers after 6 wait cycles
        do_read(32'h400, 32'h11223344, 1'b1, 6, 1'b0);
        // 2. same address hits
        do_read(32'h400, 32'h11223344, 1'b0, 0, 1'b0);
        // 3. set 0: tags 1, 0, 2; 0x600 evicts the 0x500 line
        do_read(32'h500, 32'h55550500, 1'b1, 2, 1'b0);
        do_read(32'h400, 32'h11223344, 1'b0, 0, 1'b0);
        do_read(32'h600, 32'h66660600, 1'b1, 3, 1'b0);
        do_read(32'h400, 32'h11223344, 1'b0, 0, 1'b0);
        do_read(32'h500, 32'h55550501, 1'b1, 1, 1'b0);
        // 4. write hit updates the cached word
        do_write(32'h400, 32'hDEADBEEF, 4);
        do_read(32'h400, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        // 5. write miss does not allocate
        do_write(32'h800, 32'h12345678, 2);
        do_read(32'h800, 32'h88880800, 1'b1, 2, 1'b0);
        // read wins over a simultaneous write
        do_read(32'h800, 32'h88880800, 1'b0, 0, 1'b1);
        do_read(32'h400, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        do_read(32'h500, 32'h55550502, 1'b1, 1, 1'b0);

        // 6. reset three cycles into a read miss
        @(posedge clk); #1;
        bus.r_en    = 1'b1;
        bus.address = 32'h700;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_sram_r_en", 32'(bus.sram_r_en), 32'd1);
        #1;
        bus.r_en = 1'b0;
        reset    = 1'b1;
        #1;
        check("mid_rst_sram_r_en", 32'(bus.sram_r_en), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        do_read(32'h400, 32'hCAFEF00D, 1'b1, 3, 1'b0);

        repeat (2) @(posedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
